sdram_port_queue: RTL
=====================

Name: sdram_port_queue

Overview:
- Per-client request queue sitting directly upstream of one sdram controller port.
- Buffers up to DEPTH read/write commands from a client that cannot tolerate the controller's variable latency (init, refresh, row activation).
- Issues the commands to the controller one at a time, in order, and returns read data to the client.
- Has a watchdog that flags a controller port that never completes an issued command.

Parameters:
- ADDR_WIDTH, 21: port address width; matches the controller's PORT_ADDR_WIDTH.
- DATA_WIDTH, 32: write and read data width.
- DQM_WIDTH, 4: byte-enable width; equals DATA_WIDTH/8.
- DEPTH, 4: queue entries; must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 1024: cycles in WAIT without sdram_ready before the timeout error is raised.

Ports:
- clk  in  1  system clock, same clock as the sdram controller's clk.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  client presents a command.
- req_ready  out  1  queue can accept; equals !full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data; ignored for reads.
- req_byte_en  in  DQM_WIDTH  byte enables.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_data  out  DATA_WIDTH  read data; held until the next rsp_valid.
- wr_done  out  1  one-cycle pulse when a write completes.
- sdram_addr  out  ADDR_WIDTH  to controller port_addr.
- sdram_data  out  DATA_WIDTH  to controller port_data.
- sdram_byte_en  out  DQM_WIDTH  to controller port_byte_en.
- sdram_wr  out  1  to controller port_wr.
- sdram_rd  out  1  to controller port_rd.
- sdram_available  in  1  from controller port_available.
- sdram_ready  in  1  from controller port_ready; one-cycle completion pulse, read data valid the same cycle.
- sdram_q  in  DATA_WIDTH  from controller port_q.
- level  out  $clog2(DEPTH)+1  entries currently queued.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values (all outputs):
  - req_ready = 1; rsp_valid = 0; rsp_data = 0; wr_done = 0.
  - sdram_wr = 0; sdram_rd = 0; sdram_addr/sdram_data/sdram_byte_en = 0.
  - level = 0; timeout_err = 0.
  - State = IDLE; FIFO pointers = 0.
- FIFO:
  - Push when req_valid && req_ready.
  - Entry layout: {write, addr, data, byte_en}.
  - Pointers wrap modulo DEPTH; level tracks occupancy from 0 to DEPTH.
  - Push and pop in the same cycle leave level unchanged.
  - Push when full is impossible because req_ready is 0.
  - No bypass: a command pushed in cycle N can reach sdram_* at the earliest in cycle N+2.
- State machine:
  - IDLE: if level > 0 && sdram_available, load the head entry into the sdram_* registers, pop it, and go to ISSUE.
  - ISSUE: exactly one cycle. Drive sdram_wr or sdram_rd = 1 according to the entry's write bit. Next state is WAIT. The strobe is deasserted on leaving ISSUE.
  - WAIT: sdram_addr/data/byte_en stay stable.
    - On sdram_ready: for a read, rsp_data <= sdram_q and rsp_valid pulses the next cycle; for a write, wr_done pulses the next cycle. Then go to IDLE.
    - Otherwise the watchdog counter increments. When it reaches TIMEOUT_CYCLES, set timeout_err and stay in WAIT.
- Throughput: at most one command in flight. Back-to-back issue is possible the cycle after a completion, provided sdram_available is 1.
- sdram_ready outside WAIT (spurious): ignored, no response is generated.
- sdram_available low in IDLE: the queue holds and keeps accepting pushes until full.
- Responses have no backpressure. The client must accept rsp_valid and wr_done whenever they pulse.
- Reset mid-operation:
  - The queue is flushed and the state returns to IDLE.
  - An in-flight controller command is abandoned; a later sdram_ready is ignored.
  - timeout_err is cleared only by reset.
- Ordering: responses are strictly in request order.

Decomposition:
- Shared package sdram_pkg:
  - Typedef for the queue entry struct.
  - State enum {IDLE, ISSUE, WAIT}.
  - Function computing the level width from DEPTH.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop, level, full/empty), instantiated once.

Test Plan:
- Single write {addr 21'h002020, data 32'h1234, be 4'hf} then a read of 21'h002020 → one sdram_wr pulse, then wr_done; one sdram_rd pulse, then rsp_valid with rsp_data = 32'h1234.
- Push 4 writes (21'h002020–002023) back-to-back while sdram_available = 0 → req_ready drops after the 4th, level = 4; raising sdram_available issues all 4 in order, each waiting for sdram_ready; level returns to 0.
- Push 5 commands with DEPTH = 4 while sdram_available = 0 → the 5th is held (req_ready = 0); it is accepted in the cycle after the first pop.
- Inject a spurious sdram_ready in IDLE → no rsp_valid and no wr_done.
- Issue a read with sdram_ready never arriving, TIMEOUT_CYCLES = 16 → timeout_err = 1 after 16 WAIT cycles; it stays set until reset; after reset, level = 0 and the state is IDLE.
- Assert reset during WAIT with 3 entries queued → all outputs return to reset values in the next cycle; a subsequent sdram_ready produces no response.

Source files
------------

// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the sdram port queue:
//   - state_t       : issue state machine states
//   - sdram_entry_t : queue entry layout {write, addr, data, byte_en} at the
//                     default port widths (21-bit address, 32-bit data)
//   - level_width() : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam int DEF_ADDR_WIDTH = 21;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DQM_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_DQM_WIDTH-1:0]  byte_en;
    } sdram_entry_t;

    // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count. The head entry is
// presented combinationally on rdata whenever the FIFO is not empty.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (pointers/level only)
//   push, wdata  : write an entry (ignored when full)
//   pop, rdata   : retire the head entry (ignored when empty) / head entry
//   level        : entries currently stored, 0..DEPTH
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo
    import sdram_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = level_width(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == LEVEL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/sdram_port_queue.sv
// ---------------------------------------------------------------------------
// sdram_port_queue
// Per-client command queue in front of one sdram controller port. Commands
// are buffered in a DEPTH-entry FIFO and issued one at a time, in order; read
// data and write completions return to the client as one-cycle pulses. A
// watchdog raises a sticky flag if an issued command never completes.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   req_valid/ready/write/addr/
//   req_data/byte_en              : client command interface
//   rsp_valid, rsp_data           : read data pulse (data held until next)
//   wr_done                       : write completion pulse
//   sdram_addr/data/byte_en/wr/rd : registered command to the controller
//   sdram_available, sdram_ready,
//   sdram_q                       : controller status and read data
//   level                         : entries queued
//   timeout_err                   : sticky watchdog flag
// ---------------------------------------------------------------------------
module sdram_port_queue
    import sdram_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 21,
    parameter  int DATA_WIDTH     = 32,
    parameter  int DQM_WIDTH      = 4,
    parameter  int DEPTH          = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int LEVEL_W        = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [DQM_WIDTH-1:0]  req_byte_en,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  wr_done,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0] sdram_data,
    output logic [DQM_WIDTH-1:0]  sdram_byte_en,
    output logic                  sdram_wr,
    output logic                  sdram_rd,
    input  logic                  sdram_available,
    input  logic                  sdram_ready,
    input  logic [DATA_WIDTH-1:0] sdram_q,
    output logic [LEVEL_W-1:0]    level,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    // Same layout as sdram_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DQM_WIDTH-1:0]  byte_en;
    } entry_t;

    entry_t           push_entry;
    entry_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             issue;
    state_t           state;
    logic             cur_write;
    logic [CNT_W-1:0] wd_cnt;

    assign push_entry = '{write:   req_write,
                          addr:    req_addr,
                          data:    req_data,
                          byte_en: req_byte_en};

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;

    // The pop and the load of the sdram_* registers happen on the same edge,
    // so a freshly pushed entry needs one cycle in the FIFO before issue.
    assign issue = (state == IDLE) && !fifo_empty && sdram_available;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (issue),
        .rdata (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sdram_addr    <= '0;
            sdram_data    <= '0;
            sdram_byte_en <= '0;
            sdram_wr      <= 1'b0;
            sdram_rd      <= 1'b0;
            cur_write     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            wr_done       <= 1'b0;
            wd_cnt        <= '0;
            timeout_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        sdram_addr    <= head.addr;
                        sdram_data    <= head.data;
                        sdram_byte_en <= head.byte_en;
                        sdram_wr      <= head.write;
                        sdram_rd      <= !head.write;
                        cur_write     <= head.write;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    sdram_wr <= 1'b0;
                    sdram_rd <= 1'b0;
                    wd_cnt   <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (sdram_ready) begin
                        if (cur_write) begin
                            wr_done <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= sdram_q;
                        end
                        state <= IDLE;
                    end else if (wd_cnt != CNT_LIMIT) begin
                        // Saturate at the limit; the flag stays until reset.
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == CNT_LAST) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
